// File: rtl/apxm_pkg.sv
// apxm_pkg: shared widths, LSB mask helper and saturation limits
// for the apxm_mult_pipe approximate multiplier slice.
package apxm_pkg;

  localparam int DEF_W     = 24;
  localparam int DEF_OUT_W = 32;
  localparam int DEF_CW    = 5;
  localparam int DEF_SHW   = 6;

  localparam logic [DEF_OUT_W-1:0] SAT_MAX =
    {1'b0, {(DEF_OUT_W-1){1'b1}}};
  localparam logic [DEF_OUT_W-1:0] SAT_MIN =
    {1'b1, {(DEF_OUT_W-1){1'b0}}};

  // Ones everywhere except the cut LSBs; a cut of W or more clears all.
  function automatic logic [DEF_W-1:0] lsb_mask(
    input logic [DEF_CW-1:0] cut
  );
    logic [DEF_W-1:0] m;
    m = {DEF_W{1'b1}} << cut;
    if (int'(cut) >= DEF_W) m = '0;
    return m;
  endfunction

endpackage

// File: rtl/apxm_operand_mask.sv
// apxm_operand_mask: zeroes the cut LSBs of one operand,
// clamping to an all-zero operand when the cut reaches W.
module apxm_operand_mask
  import apxm_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int CW = DEF_CW
) (
  input  logic [W-1:0]  i_op,
  input  logic [CW-1:0] i_cut,
  output logic [W-1:0]  o_op
);

  logic [W-1:0] w_mask;

  always_comb begin
    w_mask = {W{1'b1}} << i_cut;
    if (int'(i_cut) >= W) w_mask = '0;
  end

  assign o_op = i_op & w_mask;

endmodule

// File: rtl/apxm_mult_pipe.sv
// apxm_mult_pipe: 3-stage approximate signed multiplier with cut/shift.
// Define APXM_SAT_EN to saturate the result instead of wrapping.
module apxm_mult_pipe
  import apxm_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CW    = DEF_CW,
  parameter int SHW   = DEF_SHW
) (
  input  logic             clk,
  input  logic             rstP,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  input  logic [CW-1:0]    a_cut,
  input  logic [CW-1:0]    b_cut,
  input  logic [SHW-1:0]   shr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] p_out,
  output logic             busy
);

  localparam int PW = 2 * W;

  logic                    r_v1;
  logic                    r_v2;
  logic                    r_v3;
  logic signed [W-1:0]     r_a1;
  logic signed [W-1:0]     r_b1;
  logic [SHW-1:0]          r_sh1;
  logic signed [PW-1:0]    r_p2;
  logic [SHW-1:0]          r_sh2;
  logic [OUT_W-1:0]        r_p3;

  logic                    w_s1_ld;
  logic                    w_s2_ld;
  logic                    w_s3_ld;
  logic                    w_acc;
  logic [W-1:0]            w_a_m;
  logic [W-1:0]            w_b_m;
  logic signed [PW-1:0]    w_prod;
  logic [OUT_W-1:0]        w_res;

  // Each stage may advance whenever the stage after it can take its data.
  assign w_s3_ld  = !r_v3 || out_ready;
  assign w_s2_ld  = !r_v2 || w_s3_ld;
  assign w_s1_ld  = !r_v1 || w_s2_ld;
  assign in_ready = w_s1_ld && !flush && !rstP;
  assign w_acc    = in_valid && in_ready;

  assign out_valid = r_v3;
  assign p_out     = r_p3;
  assign busy      = r_v1 || r_v2 || r_v3;

  apxm_operand_mask #(
    .W  (W),
    .CW (CW)
  ) u_mask_a (
    .i_op  (a_in),
    .i_cut (a_cut),
    .o_op  (w_a_m)
  );

  apxm_operand_mask #(
    .W  (W),
    .CW (CW)
  ) u_mask_b (
    .i_op  (b_in),
    .i_cut (b_cut),
    .o_op  (w_b_m)
  );

  assign w_prod = r_a1 * r_b1;

`ifdef APXM_SAT_EN
  localparam logic [OUT_W-1:0] L_MAX =
    {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] L_MIN =
    {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [PW-1:0]   w_shf;
  logic [PW-OUT_W:0]      w_hi;

  // In range when every bit above the OUT_W sign bit matches it.
  always_comb begin
    w_shf = r_p2 >>> r_sh2;
    if (int'(r_sh2) >= PW) w_shf = {PW{r_p2[PW-1]}};
    w_hi = w_shf[PW-1:OUT_W-1];
    if ((&w_hi) || !(|w_hi)) w_res = w_shf[OUT_W-1:0];
    else if (w_shf[PW-1])    w_res = L_MIN;
    else                     w_res = L_MAX;
  end
`else
  always_comb begin
    w_res = OUT_W'(r_p2 >>> r_sh2);
    if (int'(r_sh2) >= PW) w_res = {OUT_W{r_p2[PW-1]}};
  end
`endif

  always_ff @(posedge clk or posedge rstP) begin
    if (rstP) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (flush) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else begin
      if (w_s1_ld) r_v1 <= w_acc;
      if (w_s2_ld) r_v2 <= r_v1;
      if (w_s3_ld) r_v3 <= r_v2;
    end
  end

  always_ff @(posedge clk or posedge rstP) begin
    if (rstP) begin
      r_a1  <= '0;
      r_b1  <= '0;
      r_sh1 <= '0;
    end else if (!flush && w_s1_ld && w_acc) begin
      r_a1  <= w_a_m;
      r_b1  <= w_b_m;
      r_sh1 <= shr;
    end
  end

  always_ff @(posedge clk or posedge rstP) begin
    if (rstP) begin
      r_p2  <= '0;
      r_sh2 <= '0;
    end else if (!flush && w_s2_ld && r_v1) begin
      r_p2  <= w_prod;
      r_sh2 <= r_sh1;
    end
  end

  always_ff @(posedge clk or posedge rstP) begin
    if (rstP) begin
      r_p3 <= '0;
    end else if (!flush && w_s3_ld && r_v2) begin
      r_p3 <= w_res;
    end
  end

endmodule
